// File: rtl/mips_ctrl_pkg.sv
// Shared opcode constants, FSM states and datapath control encodings for the multi-cycle MIPS control.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mips_ctrl_pkg;

   // Opcodes recognised by the control unit (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [3:0] {
      ST_RESET, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR,
      ST_R_EXEC, ST_R_WB, ST_I_EXEC, ST_I_WB, ST_BRANCH, ST_JUMP, ST_TRAP
   } state_t;

   typedef enum logic [2:0] {
      CLS_R, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL
   } op_class_t;

   // alu_op encodings
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_LOGIC = 2'b11;

   // alu_src_b encodings
   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

   // pc_source encodings
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // load_size encodings
   localparam logic [1:0] LS_WORD   = 2'b00;
   localparam logic [1:0] LS_HALF_S = 2'b01;
   localparam logic [1:0] LS_HALF_U = 2'b10;

endpackage

// File: rtl/mips_opcode_classify.sv
// Maps an opcode to its instruction class, load width and immediate extension mode.
// Latency: purely combinational.
// Backpressure: none.
module mips_opcode_classify
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   output op_class_t  op_class,
   output logic [1:0] load_size,
   output logic       zero_ext
);

   // Opcode decode; anything unlisted is trapped as illegal
   always_comb begin
      op_class  = CLS_ILLEGAL;
      load_size = LS_WORD;
      zero_ext  = 1'b0;
      case (opcode)
         OP_RTYPE: op_class = CLS_R;
         OP_ADDI:  op_class = CLS_IALU;
         OP_ANDI, OP_ORI: begin
            op_class = CLS_IALU;
            zero_ext = 1'b1;
         end
         OP_LW:    op_class = CLS_LOAD;
         OP_LH: begin
            op_class  = CLS_LOAD;
            load_size = LS_HALF_S;
         end
         OP_LHU: begin
            op_class  = CLS_LOAD;
            load_size = LS_HALF_U;
         end
         OP_SW:    op_class = CLS_STORE;
         OP_BEQ:   op_class = CLS_BRANCH;
         OP_J:     op_class = CLS_JUMP;
         default:  op_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing, illegal-op trap, retire counter.
// Latency: 3-5 cycles per instruction from FETCH to retire, plus one cycle per mem_ready=0 cycle in a memory state.
// Backpressure: FETCH, MEM_RD and MEM_WR hold their strobes stable until mem_ready (ignored when MEM_HANDSHAKE=0).
module mips_multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter int CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic             zero_ext,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic [1:0]       load_size,
   output logic             illegal_op,
   output logic             retired,
   output logic [CNT_W-1:0] retire_count
);

   state_t     state, state_nxt;
   op_class_t  dec_cls, cls_q;
   logic [1:0] dec_ls, ls_q;
   logic       dec_zext, zext_q;
   logic       rdy;

   assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

   mips_opcode_classify u_classify (
      .opcode    (opcode),
      .op_class  (dec_cls),
      .load_size (dec_ls),
      .zero_ext  (dec_zext)
   );

   // State register; reset forces RESET so every strobe drops at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_RESET;
      else        state <= state_nxt;
   end

   // Capture the decoded class in DECODE so later IR changes are ignored
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cls_q  <= CLS_ILLEGAL;
         ls_q   <= LS_WORD;
         zext_q <= 1'b0;
      end else if (state == ST_DECODE) begin
         cls_q  <= dec_cls;
         ls_q   <= dec_ls;
         zext_q <= dec_zext;
      end
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       retire_count <= '0;
      else if (retired) retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // Next-state and output decode; only FETCH/MEM_WR strobes depend on mem_ready
   always_comb begin
      state_nxt     = state;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      zero_ext      = 1'b0;
      alu_src_b     = SRCB_B;
      alu_op        = ALUOP_ADD;
      pc_source     = PCSRC_ALU;
      load_size     = LS_WORD;
      illegal_op    = 1'b0;
      retired       = 1'b0;
      case (state)
         ST_RESET: state_nxt = ST_FETCH;
         ST_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            if (rdy) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               state_nxt = ST_DECODE;
            end
         end
         ST_DECODE: begin
            alu_src_b = SRCB_IMM_SL2;
            case (dec_cls)
               CLS_R:      state_nxt = ST_R_EXEC;
               CLS_IALU:   state_nxt = ST_I_EXEC;
               CLS_LOAD,
               CLS_STORE:  state_nxt = ST_MEM_ADDR;
               CLS_BRANCH: state_nxt = ST_BRANCH;
               CLS_JUMP:   state_nxt = ST_JUMP;
               default:    state_nxt = ST_TRAP;
            endcase
         end
         ST_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_nxt = (cls_q == CLS_STORE) ? ST_MEM_WR : ST_MEM_RD;
         end
         ST_MEM_RD: begin
            mem_read  = 1'b1;
            iord      = 1'b1;
            load_size = ls_q;
            if (rdy) state_nxt = ST_MEM_WB;
         end
         ST_MEM_WB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            load_size  = ls_q;
            retired    = 1'b1;
            state_nxt  = ST_FETCH;
         end
         ST_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (rdy) begin
               retired   = 1'b1;
               state_nxt = ST_FETCH;
            end
         end
         ST_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
            state_nxt = ST_R_WB;
         end
         ST_R_WB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            retired   = 1'b1;
            state_nxt = ST_FETCH;
         end
         ST_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = zext_q ? ALUOP_LOGIC : ALUOP_ADD;
            zero_ext  = zext_q;
            state_nxt = ST_I_WB;
         end
         ST_I_WB: begin
            reg_write = 1'b1;
            retired   = 1'b1;
            state_nxt = ST_FETCH;
         end
         ST_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALUOP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            retired       = 1'b1;
            state_nxt     = ST_FETCH;
         end
         ST_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
            retired   = 1'b1;
            state_nxt = ST_FETCH;
         end
         ST_TRAP: begin
            illegal_op = 1'b1;
            state_nxt  = ST_FETCH;
         end
         default: state_nxt = ST_RESET;
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: table of single instructions, async reset and counter wrap, then random traffic.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: mem_ready stalls are scripted in the table and randomised in the final phase.
module tb_mips_multicycle_control;

   typedef struct packed {
      logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
      logic       mem_to_reg, reg_dst, reg_write, alu_src_a, zero_ext;
      logic [1:0] alu_src_b, alu_op, pc_source, load_size;
      logic       illegal_op, retired;
   } ctrl_t;

   // Instruction steps as the behaviour is described, not the RTL state machine
   typedef enum int {P_RESET, P_FETCH, P_DECODE, P_EXEC, P_WB, P_ADDR, P_LOAD, P_LDWB,
                     P_STORE, P_BRANCH, P_JUMP, P_TRAP} phase_e;

   typedef struct {
      logic [5:0] op;
      int         stall_at;
      int         stalls;
      int         exp_cycles;
      logic       exp_retire;
      logic       exp_illegal;
      logic [1:0] exp_ls;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  opcode;
   logic        mem_ready;
   ctrl_t       act, act4;
   logic [31:0] cnt;
   logic [3:0]  cnt4;

   int          checks = 0;
   int          errors = 0;
   int          cyc_no = 0;

   phase_e      m_ph = P_RESET;
   phase_e      plan[$];
   logic [5:0]  m_op = 6'h00;
   logic [31:0] m_cnt = 32'd0;
   ctrl_t       last_act;

   vec_t        vt[14];
   logic [5:0]  pool[11];

   always #5 clk = ~clk;

   mips_multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(act.pc_write), .pc_write_cond(act.pc_write_cond), .iord(act.iord),
      .mem_read(act.mem_read), .mem_write(act.mem_write), .ir_write(act.ir_write),
      .mem_to_reg(act.mem_to_reg), .reg_dst(act.reg_dst), .reg_write(act.reg_write),
      .alu_src_a(act.alu_src_a), .zero_ext(act.zero_ext), .alu_src_b(act.alu_src_b),
      .alu_op(act.alu_op), .pc_source(act.pc_source), .load_size(act.load_size),
      .illegal_op(act.illegal_op), .retired(act.retired), .retire_count(cnt)
   );

   mips_multicycle_control #(.MEM_HANDSHAKE(1'b1), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(act4.pc_write), .pc_write_cond(act4.pc_write_cond), .iord(act4.iord),
      .mem_read(act4.mem_read), .mem_write(act4.mem_write), .ir_write(act4.ir_write),
      .mem_to_reg(act4.mem_to_reg), .reg_dst(act4.reg_dst), .reg_write(act4.reg_write),
      .alu_src_a(act4.alu_src_a), .zero_ext(act4.zero_ext), .alu_src_b(act4.alu_src_b),
      .alu_op(act4.alu_op), .pc_source(act4.pc_source), .load_size(act4.load_size),
      .illegal_op(act4.illegal_op), .retired(act4.retired), .retire_count(cnt4)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc_no, got, exp);
      end
   endtask

   function automatic logic [1:0] width_of(input logic [5:0] op);
      if (op == 6'h21) return 2'b01;
      if (op == 6'h25) return 2'b10;
      return 2'b00;
   endfunction

   // Expected control word for one cycle of a given step
   function automatic ctrl_t model_out(input phase_e p, input logic [5:0] op, input logic rdy);
      ctrl_t o;
      o = '0;
      case (p)
         P_FETCH:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
         P_DECODE: o.alu_src_b = 2'b11;
         P_EXEC: begin
            o.alu_src_a = 1;
            if (op == 6'h00) o.alu_op = 2'b10;
            else begin
               o.alu_src_b = 2'b10;
               if (op == 6'h0C || op == 6'h0D) begin o.alu_op = 2'b11; o.zero_ext = 1; end
            end
         end
         P_WB:     begin o.reg_write = 1; o.reg_dst = (op == 6'h00); o.retired = 1; end
         P_ADDR:   begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         P_LOAD:   begin o.mem_read = 1; o.iord = 1; o.load_size = width_of(op); end
         P_LDWB:   begin o.mem_to_reg = 1; o.reg_write = 1; o.load_size = width_of(op); o.retired = 1; end
         P_STORE:  begin o.mem_write = 1; o.iord = 1; o.retired = rdy; end
         P_BRANCH: begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; o.retired = 1; end
         P_JUMP:   begin o.pc_write = 1; o.pc_source = 2'b10; o.retired = 1; end
         P_TRAP:   o.illegal_op = 1;
         default:  o = '0;
      endcase
      return o;
   endfunction

   task automatic model_reset();
      m_ph  = P_RESET;
      m_cnt = 32'd0;
      plan.delete();
   endtask

   // Advance the model by one clock edge
   task automatic model_step(input logic [5:0] op, input logic rdy);
      case (m_ph)
         P_RESET: m_ph = P_FETCH;
         P_FETCH: if (rdy) m_ph = P_DECODE;
         P_DECODE: begin
            m_op = op;
            case (op)
               6'h00, 6'h08, 6'h0C, 6'h0D: begin plan.push_back(P_EXEC); plan.push_back(P_WB); end
               6'h21, 6'h23, 6'h25: begin plan.push_back(P_ADDR); plan.push_back(P_LOAD); plan.push_back(P_LDWB); end
               6'h2B: begin plan.push_back(P_ADDR); plan.push_back(P_STORE); end
               6'h04: plan.push_back(P_BRANCH);
               6'h02: plan.push_back(P_JUMP);
               default: plan.push_back(P_TRAP);
            endcase
            m_ph = plan.pop_front();
         end
         default: begin
            if (!(m_ph == P_LOAD || m_ph == P_STORE) || rdy) begin
               if (plan.size() > 0) m_ph = plan.pop_front();
               else                 m_ph = P_FETCH;
            end
         end
      endcase
   endtask

   // One cycle: drive, check on the falling edge, advance at the rising edge
   task automatic run_cycle(input logic [5:0] op, input logic rdy);
      ctrl_t e;
      opcode    = op;
      mem_ready = rdy;
      if (!rst_n) model_reset();
      e = model_out(m_ph, m_op, rdy);
      @(negedge clk);
      cyc_no++;
      last_act = act;
      chk("ctrl", 32'(act), 32'(e));
      chk("ctrl_w4", 32'(act4), 32'(e));
      chk("retire_count", cnt, m_cnt);
      chk("retire_count_w4", 32'(cnt4), 32'(m_cnt[3:0]));
      if (e.retired) m_cnt = m_cnt + 32'd1;
      @(posedge clk);
      #1;
      if (rst_n) model_step(op, rdy);
   endtask

   initial begin
      int   cyc;
      logic seen_ret, seen_ill;
      logic [1:0] ls_end;

      //          op     st  n  cyc ret ill ls
      vt[0]  = '{6'h00, 0, 0, 4, 1'b1, 1'b0, 2'b00};
      vt[1]  = '{6'h08, 0, 0, 4, 1'b1, 1'b0, 2'b00};
      vt[2]  = '{6'h0C, 0, 0, 4, 1'b1, 1'b0, 2'b00};
      vt[3]  = '{6'h0D, 0, 0, 4, 1'b1, 1'b0, 2'b00};
      vt[4]  = '{6'h23, 0, 0, 5, 1'b1, 1'b0, 2'b00};
      vt[5]  = '{6'h21, 4, 2, 7, 1'b1, 1'b0, 2'b01};
      vt[6]  = '{6'h25, 0, 0, 5, 1'b1, 1'b0, 2'b10};
      vt[7]  = '{6'h2B, 0, 0, 4, 1'b1, 1'b0, 2'b00};
      vt[8]  = '{6'h04, 0, 0, 3, 1'b1, 1'b0, 2'b00};
      vt[9]  = '{6'h02, 0, 0, 3, 1'b1, 1'b0, 2'b00};
      vt[10] = '{6'h3F, 0, 0, 3, 1'b0, 1'b1, 2'b00};
      vt[11] = '{6'h2B, 4, 3, 7, 1'b1, 1'b0, 2'b00};
      vt[12] = '{6'h00, 1, 2, 6, 1'b1, 1'b0, 2'b00};
      vt[13] = '{6'h01, 0, 0, 3, 1'b0, 1'b1, 2'b00};

      pool[0] = 6'h00; pool[1] = 6'h02; pool[2] = 6'h04; pool[3] = 6'h08;
      pool[4] = 6'h0C; pool[5] = 6'h0D; pool[6] = 6'h21; pool[7] = 6'h23;
      pool[8] = 6'h25; pool[9] = 6'h2B; pool[10] = 6'h3F;

      // Reset held low: outputs and counters zero
      rst_n     = 1'b0;
      opcode    = 6'h00;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      run_cycle(6'h00, 1'b1);
      run_cycle(6'h00, 1'b1);
      rst_n = 1'b1;
      run_cycle(6'h00, 1'b1);

      // One instruction per table row, measured from FETCH to its final pulse
      for (int v = 0; v < 14; v++) begin
         cyc = 0; seen_ret = 1'b0; seen_ill = 1'b0; ls_end = 2'b00;
         while (!(seen_ret || seen_ill) && cyc < 30) begin
            cyc++;
            run_cycle(vt[v].op, !(cyc >= vt[v].stall_at && cyc < vt[v].stall_at + vt[v].stalls));
            seen_ret = last_act.retired;
            seen_ill = last_act.illegal_op;
            ls_end   = last_act.load_size;
         end
         chk($sformatf("vec%0d_cycles", v), 32'(cyc), 32'(vt[v].exp_cycles));
         chk($sformatf("vec%0d_retired", v), 32'(seen_ret), 32'(vt[v].exp_retire));
         chk($sformatf("vec%0d_illegal", v), 32'(seen_ill), 32'(vt[v].exp_illegal));
         chk($sformatf("vec%0d_load_size", v), 32'(ls_end), 32'(vt[v].exp_ls));
      end

      // Async reset in the middle of a stalled store
      run_cycle(6'h2B, 1'b1);
      run_cycle(6'h2B, 1'b1);
      run_cycle(6'h2B, 1'b1);
      opcode    = 6'h2B;
      mem_ready = 1'b0;
      #2;
      chk("wr_stall_mem_write", 32'(act.mem_write), 32'd1);
      chk("wr_stall_no_retire", 32'(act.retired), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_ctrl", 32'(act), 32'd0);
      chk("async_rst_count", cnt, 32'd0);
      chk("async_rst_count_w4", 32'(cnt4), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      run_cycle(6'h2B, 1'b1);
      rst_n = 1'b1;
      run_cycle(6'h00, 1'b1);

      // 17 R-types: the 4-bit counter wraps to 1
      for (int n = 0; n < 17; n++)
         for (int c = 0; c < 4; c++) run_cycle(6'h00, 1'b1);
      chk("wrap_count_w4", 32'(cnt4), 32'd1);
      chk("wrap_count_w32", cnt, 32'd17);

      // Random opcodes every cycle, random stalls, occasional reset
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] op;
         if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
         else                           op = pool[$urandom_range(0, 10)];
         rst_n = ($urandom_range(0, 299) != 0);
         run_cycle(op, $urandom_range(0, 3) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
